// File: rtl/ascon_bdi_pack_pkg.sv
// Shared configuration for the Ascon input formatter: bdi data types and core word width.
package ascon_bdi_pack_pkg;

  typedef enum logic [2:0] {
    D_NULL  = 3'd0,
    D_NONCE = 3'd1,
    D_AD    = 3'd2,
    D_MSG   = 3'd3,
    D_TAG   = 3'd4,
    D_HASH  = 3'd5
  } data_type_e;

  localparam int CCW_CFG = 32;

endpackage

// File: rtl/ascon_bdi_pack_word_reg.sv
// Valid/ready holding register for one packed bdi word; contents read as zero when empty.
module ascon_word_reg
  import ascon_bdi_pack_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // A load in the same cycle as an accept wins, so the register can stream back-to-back.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ascon_bdi_pack.sv
// Packs a typed byte stream into CCW-bit bdi words for ascon_core.
// Define ASCON_PACK_SKID_EN for a second word register that lets filling continue while a word waits.
module ascon_bdi_pack
  import ascon_bdi_pack_pkg::*;
#(
  parameter int CCW = CCW_CFG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [$bits(data_type_e)-1:0] s_type,
  input  logic                          s_last,
  input  logic                          s_eoi,
  output logic [CCW-1:0]                bdi,
  output logic [CCW/8-1:0]              bdi_valid,
  input  logic                          bdi_ready,
  output logic [$bits(data_type_e)-1:0] bdi_type,
  output logic                          bdi_eot,
  output logic                          bdi_eoi,
  output logic                          err
);

  localparam int NB = CCW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NB - 1);

  typedef struct packed {
    logic [CCW-1:0] data;
    logic [NB-1:0]  mask;
    data_type_e     dtype;
    logic           eot;
    logic           eoi;
  } word_t;

  localparam int WW = $bits(word_t);

  logic [CCW-1:0] data_q, data_d;
  logic [NB-1:0]  mask_q, mask_d;
  data_type_e     type_q, type_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic  s_fire, last_eff, complete;
  word_t word_new, out_w;
  logic  out_in_valid, out_in_ready, out_valid;
  word_t out_in_data;

  assign s_fire   = s_valid && s_ready;
  // A stray eoi still closes the segment so the core never waits on a missing eot.
  assign last_eff = s_last || s_eoi;
  assign complete = s_fire && (cnt_q == LAST_LANE || last_eff);

  always_comb begin
    word_new.data  = data_q | (CCW'(s_data) << {cnt_q, 3'b000});
    word_new.mask  = mask_q | (NB'(1'b1) << cnt_q);
    word_new.dtype = (cnt_q == '0) ? data_type_e'(s_type) : type_q;
    word_new.eot   = last_eff;
    word_new.eoi   = s_eoi;
  end

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    type_d = type_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (s_fire) begin
      if ((cnt_q != '0 && s_type != type_q) || (s_eoi && !s_last))
        err_d = 1'b1;
      if (complete) begin
        data_d = '0;
        mask_d = '0;
        type_d = D_NULL;
        cnt_d  = '0;
      end else begin
        data_d = word_new.data;
        mask_d = word_new.mask;
        type_d = word_new.dtype;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      mask_q <= '0;
      type_q <= D_NULL;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      type_q <= type_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

`ifdef ASCON_PACK_SKID_EN
  logic  hold_valid, hold_in_ready;
  word_t hold_data;

  // A waiting word always leaves before a freshly completed one.
  assign out_in_valid = hold_valid || complete;
  assign out_in_data  = hold_valid ? hold_data : word_new;
  assign s_ready      = hold_in_ready;

  ascon_word_reg #(.W(WW)) u_hold_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (complete && (hold_valid || !out_in_ready)),
    .in_data_i   (word_new),
    .in_ready_o  (hold_in_ready),
    .out_valid_o (hold_valid),
    .out_data_o  (hold_data),
    .out_ready_i (out_in_ready)
  );
`else
  localparam logic FILL = 1'b0;
  localparam logic OUT  = 1'b1;

  logic state;

  assign state        = out_valid ? OUT : FILL;
  assign out_in_valid = complete;
  assign out_in_data  = word_new;
  assign s_ready      = out_in_ready && (state == FILL);
`endif

  ascon_word_reg #(.W(WW)) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (out_in_valid),
    .in_data_i   (out_in_data),
    .in_ready_o  (out_in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_w),
    .out_ready_i (bdi_ready)
  );

  assign bdi       = out_w.data;
  assign bdi_valid = out_valid ? out_w.mask : '0;
  assign bdi_type  = out_w.dtype;
  assign bdi_eot   = out_w.eot;
  assign bdi_eoi   = out_w.eoi;
  assign err       = err_q;

endmodule

// File: tb/tb_ascon_bdi_pack.sv
// Scoreboard bench for ascon_bdi_pack at CCW=32; expected words are queued as bytes are issued.
module tb_ascon_bdi_pack;
  import ascon_bdi_pack_pkg::*;

  logic        clk, rst;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_last, s_eoi;
  logic [2:0]  s_type;
  logic [31:0] bdi;
  logic [3:0]  bdi_valid;
  logic        bdi_ready;
  logic [2:0]  bdi_type;
  logic        bdi_eot, bdi_eoi, err;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
    logic [2:0]  dtype;
    logic        eot;
    logic        eoi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;

  ascon_bdi_pack #(.CCW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_type    (s_type),
    .s_last    (s_last),
    .s_eoi     (s_eoi),
    .bdi       (bdi),
    .bdi_valid (bdi_valid),
    .bdi_ready (bdi_ready),
    .bdi_type  (bdi_type),
    .bdi_eot   (bdi_eot),
    .bdi_eoi   (bdi_eoi),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [3:0] m, input data_type_e t,
                              input logic eot, input logic eoi);
    exp_t e;
    e.data = d; e.mask = m; e.dtype = 3'(t); e.eot = eot; e.eoi = eoi;
    return e;
  endfunction

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bdi_valid != 4'h0 && bdi_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h mask %0h, expected none", bdi, bdi_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bdi_word", {23'd0, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi}, {23'd0, e});
      end
    end
  end

  // Inputs change 1ns after the rising edge; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] d, input data_type_e t, input logic l, input logic e);
    logic ok;
    int   n;
    n = 0;
    s_data = d; s_type = 3'(t); s_last = l; s_eoi = e; s_valid = 1'b1;
    while (1'b1) begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) stalls++;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0h not accepted, required within 100 cycles", d);
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; s_eoi = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    chk({tag, "_bdi"}, 64'(bdi), 64'd0);
    chk({tag, "_bdi_valid"}, 64'(bdi_valid), 64'd0);
    chk({tag, "_bdi_type"}, 64'(bdi_type), 64'(D_NULL));
    chk({tag, "_eot_eoi"}, 64'({bdi_eot, bdi_eoi}), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic stable;
    logic sready_ok;
    int   n;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_type = 3'(D_NULL);
    s_last = 1'b0; s_eoi = 1'b0; bdi_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // AD 01..05: one full word, then a single-byte tail carrying eot.
    sb.push_back(mk(32'h04030201, 4'hF, D_AD, 1'b0, 1'b0));
    sb.push_back(mk(32'h00000005, 4'h1, D_AD, 1'b1, 1'b0));
    for (int i = 1; i <= 5; i++) send(8'(i), D_AD, i == 5, 1'b0);

    // MSG A0..A3 with last+eoi; word visible the cycle after the last byte.
    sb.push_back(mk(32'hA3A2A1A0, 4'hF, D_MSG, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), D_MSG, i == 3, i == 3);
    chk("latency_valid", 64'(bdi_valid), 64'h0F);
    idle(3);

    // Backpressure: word held 10 cycles.
    bdi_ready = 1'b0;
    sb.push_back(mk(32'hD3D2D1D0, 4'hF, D_TAG, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), D_TAG, i == 3, 1'b0);
    stable = 1'b1;
    sready_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bdi !== 32'hD3D2D1D0 || bdi_valid !== 4'hF || bdi_type !== 3'(D_TAG) || bdi_eot !== 1'b1)
        stable = 1'b0;
`ifdef ASCON_PACK_SKID_EN
      if (s_ready !== 1'b1) sready_ok = 1'b0;
`else
      if (s_ready !== 1'b0) sready_ok = 1'b0;
`endif
    end
    chk("hold_stable", 64'(stable), 64'd1);
    chk("hold_s_ready", 64'(sready_ok), 64'd1);
    @(posedge clk);
    #1;
    bdi_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_accept_s_ready", 64'(s_ready), 64'd1);
    chk("after_accept_valid", 64'(bdi_valid), 64'd0);
    chk("err_clean_traffic", 64'(err), 64'd0);

    // Type change at byte_cnt=2: flagged, byte still packed into the AD word.
    sb.push_back(mk(32'h24232221, 4'hF, D_AD, 1'b1, 1'b0));
    send(8'h21, D_AD, 1'b0, 1'b0);
    send(8'h22, D_AD, 1'b0, 1'b0);
    send(8'h23, D_MSG, 1'b0, 1'b0);
    chk("err_type_change", 64'(err), 64'd1);
    send(8'h24, D_AD, 1'b1, 1'b0);
    idle(5);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset mid-word discards the partial bytes and clears err.
    send(8'h31, D_NONCE, 1'b0, 1'b0);
    send(8'h32, D_NONCE, 1'b0, 1'b0);
    send(8'h33, D_NONCE, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midreset");
    rst = 1'b0;
    sb.push_back(mk(32'h00000011, 4'h1, D_NONCE, 1'b1, 1'b0));
    send(8'h11, D_NONCE, 1'b1, 1'b0);
    idle(3);
    chk("err_after_reset", 64'(err), 64'd0);

    // eoi without last closes the segment and raises err.
    sb.push_back(mk(32'h00000041, 4'h1, D_HASH, 1'b1, 1'b1));
    send(8'h41, D_HASH, 1'b0, 1'b1);
    chk("err_eoi_no_last", 64'(err), 64'd1);
    idle(3);

    // 16 continuous bytes with bdi_ready held high.
    sb.push_back(mk(32'h53525150, 4'hF, D_MSG, 1'b0, 1'b0));
    sb.push_back(mk(32'h57565554, 4'hF, D_MSG, 1'b0, 1'b0));
    sb.push_back(mk(32'h5B5A5958, 4'hF, D_MSG, 1'b0, 1'b0));
    sb.push_back(mk(32'h5F5E5D5C, 4'hF, D_MSG, 1'b1, 1'b1));
    stalls = 0;
    for (int i = 0; i < 16; i++) send(8'h50 + 8'(i), D_MSG, i == 15, i == 15);
`ifdef ASCON_PACK_SKID_EN
    chk("stream_stalls", 64'(stalls), 64'd0);
`else
    chk("stream_stalls", 64'(stalls), 64'd3);
`endif

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
